// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, latency defaults and opcode class decode
package mdu_pkg;

  localparam int CNT_W         = 6;
  localparam int MULT_LAT_DEF  = 5;
  localparam int DIV_LAT_DEF   = 10;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mult_class(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_hilo_class(input logic [3:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// rtl/mdu_issue_ctrl_if.sv - pipeline <-> MDU issue controller signal bundle
interface mdu_issue_ctrl_if;

  logic       req;
  logic       e_valid;
  logic [3:0] e_op;
  logic [3:0] d_op;
  logic       mdu_busy;
  logic       start_e;
  logic [3:0] mdu_op;
  logic       stall_d;
  logic       run;
  logic       err;

  modport master (
    output req, e_valid, e_op, d_op, mdu_busy,
    input  start_e, mdu_op, stall_d, run, err
  );

  modport slave (
    input  req, e_valid, e_op, d_op, mdu_busy,
    output start_e, mdu_op, stall_d, run, err
  );

endinterface

// File: rtl/mdu_lat_counter.sv
// rtl/mdu_lat_counter.sv - loadable down-counter tracking remaining MDU latency
module mdu_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - MDU issue/stall tracker; MDU_BUSY_CHECK_EN enables the sticky busy-mismatch flag
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input logic             clk,
  input logic             reset,
  mdu_issue_ctrl_if.slave bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             e_mult;
  logic             start_e;
  logic             run;

  assign e_mult = bus.e_valid & is_mult_class(bus.e_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // req freezes the tracker in lockstep with the MDU itself
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (start_e) state_d = ST_RUN;
    end else begin
      if (!bus.req && cnt_zero) state_d = ST_IDLE;
    end
  end

  always_comb begin
    run      = (state_q == ST_RUN);
    start_e  = e_mult & ~bus.req & (state_q == ST_IDLE);
    cnt_load = start_e;
    cnt_dec  = run & ~bus.req;
    load_val = ((bus.e_op == OP_MULT) || (bus.e_op == OP_MULTU)) ? CNT_W'(MULT_LAT)
                                                                 : CNT_W'(DIV_LAT);
  end

  mdu_lat_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign bus.start_e = start_e;
  assign bus.run     = run;
  assign bus.mdu_op  = bus.e_valid ? bus.e_op : OP_NOP;
  assign bus.stall_d = (is_mult_class(bus.d_op) | is_hilo_class(bus.d_op)) & (run | start_e);

`ifdef MDU_BUSY_CHECK_EN
  logic err_q, err_d;

  // busy with nothing tracked, or a mult-class op leaking into E while running
  always_comb begin
    err_d = err_q | (bus.mdu_busy & ~run & ~start_e & ~bus.req) | (run & e_mult);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = cnt;
`else
  assign bus.err = 1'b0;

  logic             unused_busy;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_busy = bus.mdu_busy;
  assign unused_cnt  = cnt;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - directed self-checking bench for mdu_issue_ctrl
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

`ifdef MDU_BUSY_CHECK_EN
  localparam logic [31:0] CHK = 32'd1;
`else
  localparam logic [31:0] CHK = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if bus();

  mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int r_cnt, s_cnt, st_cnt, p_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req      = 1'b0;
    bus.e_valid  = 1'b0;
    bus.e_op     = 4'd0;
    bus.d_op     = 4'd0;
    bus.mdu_busy = 1'b0;
  endtask

  // Follows one tracked op; returns at the first cycle sampled with run=0.
  task automatic track(input int busy_len, input logic [31:0] req_pat, input int probe_i,
                       output int run_cnt, output int stall_cnt, output int starts,
                       output int probe_cnt);
    run_cnt = 0; stall_cnt = 0; starts = 0; probe_cnt = -1;
    for (int i = 0; i < 32; i++) begin
      bus.req      = req_pat[i];
      bus.mdu_busy = (i < busy_len);
      bus.e_valid  = 1'b0;
      #2;
      if (i == probe_i) probe_cnt = int'(dut.u_cnt.cnt_q);
      if (!bus.run) break;
      run_cnt++;
      if (bus.stall_d) stall_cnt++;
      if (bus.start_e) starts++;
      adv();
    end
    bus.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    adv();
    adv();
    #2;
    check_eq("rst_run", bus.run, 0);
    check_eq("rst_start", bus.start_e, 0);
    check_eq("rst_stall", bus.stall_d, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_mdu_op", bus.mdu_op, 0);
    check_eq("rst_cnt", dut.u_cnt.cnt_q, 0);
    reset = 1'b0;
    adv();

    // MULT with MFLO waiting in D
    bus.e_valid = 1'b1; bus.e_op = OP_MULT; bus.d_op = OP_MFLO;
    #2;
    check_eq("mult_start", bus.start_e, 1);
    check_eq("mult_stall0", bus.stall_d, 1);
    check_eq("mult_mdu_op", bus.mdu_op, 1);
    check_eq("mult_run0", bus.run, 0);
    adv();
    track(6, 32'd0, 0, r_cnt, s_cnt, st_cnt, p_cnt);
    check_eq("mult_run_len", r_cnt, 6);
    check_eq("mult_stall_len", s_cnt, 6);
    check_eq("mult_no_restart", st_cnt, 0);
    check_eq("mult_cnt_load", p_cnt, 5);
    check_eq("mult_stall_end", bus.stall_d, 0);

    // DIVU with a 3-cycle req freeze during RUN
    bus.e_valid = 1'b1; bus.e_op = OP_DIVU; bus.d_op = OP_MTHI;
    #2;
    check_eq("divu_start", bus.start_e, 1);
    adv();
    track(14, 32'b11100, 5, r_cnt, s_cnt, st_cnt, p_cnt);
    check_eq("divu_run_len", r_cnt, 14);
    check_eq("divu_stall_len", s_cnt, 14);
    check_eq("divu_no_restart", st_cnt, 0);
    check_eq("divu_cnt_frozen", p_cnt, 8);

    // MULT in E coinciding with req
    bus.e_valid = 1'b1; bus.e_op = OP_MULT; bus.d_op = 4'd9; bus.req = 1'b1;
    #2;
    check_eq("req_start", bus.start_e, 0);
    check_eq("req_stall_add", bus.stall_d, 0);
    check_eq("req_mdu_op", bus.mdu_op, 1);
    bus.d_op = OP_MFHI;
    #1;
    check_eq("req_stall_mfhi", bus.stall_d, 0);
    adv();
    bus.req = 1'b0; bus.e_valid = 1'b0; bus.d_op = 4'd0;
    #2;
    check_eq("req_run", bus.run, 0);

    // MULT then MULTU back to back
    bus.e_valid = 1'b1; bus.e_op = OP_MULT; bus.d_op = OP_MULTU;
    #2;
    check_eq("b2b_start1", bus.start_e, 1);
    adv();
    track(6, 32'd0, 99, r_cnt, s_cnt, st_cnt, p_cnt);
    check_eq("b2b_run1", r_cnt, 6);
    check_eq("b2b_stall1", s_cnt, 6);
    bus.e_valid = 1'b1; bus.e_op = OP_MULTU; bus.d_op = 4'd0;
    #2;
    check_eq("b2b_start2", bus.start_e, 1);
    check_eq("b2b_mdu_op2", bus.mdu_op, 2);
    adv();
    track(6, 32'd0, 0, r_cnt, s_cnt, st_cnt, p_cnt);
    check_eq("b2b_run2", r_cnt, 6);
    check_eq("b2b_cnt2", p_cnt, 5);

    // DIV interrupted by reset at cnt=4
    bus.e_valid = 1'b1; bus.e_op = OP_DIV; bus.d_op = OP_DIV;
    #2;
    check_eq("rdiv_start", bus.start_e, 1);
    adv();
    bus.e_valid = 1'b0; bus.mdu_busy = 1'b1;
    for (int i = 0; i < 6; i++) adv();
    #2;
    check_eq("rdiv_cnt4", dut.u_cnt.cnt_q, 4);
    check_eq("rdiv_stall_pre", bus.stall_d, 1);
    reset = 1'b1;
    adv();
    reset = 1'b0; bus.mdu_busy = 1'b0;
    #2;
    check_eq("rdiv_run", bus.run, 0);
    check_eq("rdiv_stall", bus.stall_d, 0);
    check_eq("rdiv_err", bus.err, 0);

    // Stray mult-class op reaching E while RUN
    bus.e_valid = 1'b1; bus.e_op = OP_MULT; bus.d_op = 4'd0;
    #2;
    check_eq("stray_start1", bus.start_e, 1);
    adv();
    bus.mdu_busy = 1'b1; bus.e_valid = 1'b1; bus.e_op = OP_DIV;
    #2;
    check_eq("stray_no_start", bus.start_e, 0);
    check_eq("stray_run", bus.run, 1);
    adv();
    bus.e_valid = 1'b0;
    #2;
    check_eq("stray_err", bus.err, CHK);
    reset = 1'b1; bus.mdu_busy = 1'b0;
    adv();
    reset = 1'b0;
    #2;
    check_eq("stray_err_clr", bus.err, 0);

    // mdu_busy asserted with nothing in flight
    idle_inputs();
    bus.mdu_busy = 1'b1;
    #2;
    check_eq("busy_err_pre", bus.err, 0);
    adv();
    bus.mdu_busy = 1'b0;
    #2;
    check_eq("busy_err_set", bus.err, CHK);
    adv();
    #2;
    check_eq("busy_err_hold", bus.err, CHK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, mult/multu countdown value; equals the MDU multiply latency constant.
REQ-002 Parameter DIV_LAT, default 10, div/divu countdown value; equals the MDU divide latency constant.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req  in  1  exception/interrupt request; MDU-freeze cycle.
REQ-006 e_valid  in  1  E-stage instruction valid.
REQ-007 e_op  in  4  E-stage MDU opcode (package encoding).
REQ-008 d_op  in  4  D-stage MDU opcode (package encoding).
REQ-009 mdu_busy  in  1  busy from the multiply-divide unit.
REQ-010 start_e  out  1  start strobe to the MDU.
REQ-011 mdu_op  out  4  opcode to the MDU; equals e_op when e_valid, else NOP.
REQ-012 stall_d  out  1  freeze F/D, bubble into E.
REQ-013 run  out  1  high while a mult/div is being tracked.
REQ-014 err  out  1  sticky busy-mismatch flag (see Configuration).

Function
REQ-015 The opcode classes SHALL be: mult-class = MULT, MULTU, DIV, DIVU; hilo-class = MFHI, MFLO, MTHI, MTLO; all others are non-MDU.
REQ-016 start_e SHALL be combinational: e_valid & mult-class(e_op) & !req & state==IDLE.
REQ-017 The FSM SHALL have states IDLE and RUN plus a 6-bit down-counter cnt.
REQ-018 IDLE->RUN SHALL occur on the edge where start_e=1; cnt loads MULT_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
REQ-019 In RUN with req=0: cnt!=0 -> cnt-1; cnt==0 -> IDLE.
REQ-020 With req=1, state and cnt SHALL hold, matching the MDU freeze.
REQ-021 A mult-class op SHALL stay in RUN for LAT+1 non-req cycles; IDLE is re-entered on the same edge the MDU writes hi/lo and drops busy.
REQ-022 stall_d SHALL be (mult-class(d_op) | hilo-class(d_op)) & (state==RUN | start_e).
REQ-023 stall_d SHALL be 0 for non-MDU d_op regardless of state.
REQ-024 run SHALL equal state==RUN.
REQ-025 A mult-class e_op arriving in RUN SHALL NOT start and SHALL NOT occur, since stall_d prevents it; if it occurs anyway, it SHALL be ignored and err SHALL be set when checking is enabled.
REQ-026 Simultaneous req and mult-class e_op SHALL produce start_e=0 with the state remaining IDLE.

Reset
REQ-027 On reset: state=IDLE, cnt=0, err=0; start_e=0 and stall_d=0 unless inputs demand otherwise combinationally in IDLE.
REQ-028 Reset in RUN mid-operation SHALL return to IDLE on the next edge with no residual stall.

Configuration
REQ-029 Macro MDU_BUSY_CHECK_EN defined: err sets, sticky until reset, when mdu_busy=1 in IDLE with start_e=0 and req=0, or under the REQ-025 condition.
REQ-030 Macro MDU_BUSY_CHECK_EN undefined: err SHALL be tied to 0 and the check logic SHALL be absent.

Structure
REQ-031 The opcode encodings SHALL live in shared package mdu_pkg: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; the same package SHALL hold the MULT_LAT and DIV_LAT defaults.
REQ-032 mdu_pkg SHALL also hold the class-decode functions is_mult_class and is_hilo_class.
REQ-033 One sub-module, mdu_lat_counter (load, hold, decrement, zero), is natural; no other sub-modules.

Verification
REQ-034 MULT issued in IDLE, e_valid=1 -> start_e=1 for 1 cycle; run=1 for 6 cycles; a MFLO held in D stalls 6 cycles; run and mdu_busy fall on the same edge.
REQ-035 DIVU issued, req pulsed 3 cycles during RUN -> run=1 for 11+3=14 cycles; cnt frozen during req.
REQ-036 MULT in E with req=1 in the same cycle -> start_e=0, run stays 0, stall_d=0 for an ADD in D.
REQ-037 DIV issued, reset asserted at cnt=4 -> next cycle run=0, stall_d=0, err=0.
REQ-038 Back-to-back MULT then MULTU -> second op stalls in D 6 cycles, starts on the cycle after run falls.
REQ-039 With MDU_BUSY_CHECK_EN defined, mdu_busy forced to 1 in IDLE -> err=1 next cycle and held; without the macro, err=0 throughout.
